// File: rtl/rlbp_code_collector.sv
// Assembles the serial rLBP comparator bitstream into tagged codes and buffers
// them in a first-word-fall-through FIFO drained by firmware, with sticky error flags and an interrupt.
module rlbp_code_collector #(
    parameter int CODE_BITS = 12,
    parameter int TAG_BITS  = 4,
    parameter int DEPTH     = 8,
    parameter int IRQ_THR   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_n,
    input  logic                          start_i,
    input  logic                          bit_i,
    input  logic                          bit_vld_i,
    input  logic                          done_i,
    input  logic                          rd_en_i,
    input  logic                          clr_flags_i,
    output logic                          rd_valid_o,
    output logic [TAG_BITS+CODE_BITS-1:0] rd_data_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          busy_o,
    output logic                          err_len_o,
    output logic                          ovf_o,
    output logic                          irq_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CODE_BITS + 2);
    localparam int DW = TAG_BITS + CODE_BITS;

    // Handshake: a FIFO entry transfers at the rising edge where rd_en_i && rd_valid_o.
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [CODE_BITS-1:0]  sr;
    logic [CW-1:0]         cnt;
    logic [TAG_BITS-1:0]   tag;
    logic [DW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  err_len;
    logic                  ovf;
    logic                  irq;

    logic                  in_shift;
    logic [CW-1:0]         cnt_final;
    logic [CODE_BITS-1:0]  sr_final;
    logic                  frame_end;
    logic                  good;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  err_set;

    always_comb begin
        in_shift  = (state == SHIFT);
        cnt_final = cnt;
        sr_final  = sr;
        // A bit arriving together with done_i is part of the frame.
        if (bit_vld_i) begin
            sr_final = {sr[CODE_BITS-2:0], bit_i};
            if (cnt != CW'(CODE_BITS + 1))
                cnt_final = cnt + 1'b1;
        end
        frame_end = in_shift && done_i;
        good      = frame_end && (cnt_final == CW'(CODE_BITS));
        full      = (level == LW'(DEPTH));
        pop       = rd_en_i && (level != '0);
        push      = good && (!full || pop);
        drop      = good && full && !pop;
        err_set   = (frame_end && !good) || (in_shift && start_i && !done_i);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            tag     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            err_len <= 1'b0;
            ovf     <= 1'b0;
            irq     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= SHIFT;
                        sr    <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (start_i) begin
                        sr  <= '0;
                        cnt <= '0;
                    end else if (done_i) begin
                        state <= IDLE;
                    end else begin
                        sr  <= sr_final;
                        cnt <= cnt_final;
                    end
                end
                default: state <= IDLE;
            endcase

            // Every frame end consumes a tag so dropped frames leave gaps.
            if (frame_end)
                tag <= tag + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            err_len <= err_set | (err_len & ~clr_flags_i);
            ovf     <= drop    | (ovf & ~clr_flags_i);
            irq     <= (level >= LW'(IRQ_THR)) | err_len | ovf;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n && push)
            mem[wr_ptr] <= {tag, sr_final};
    end

    assign rd_valid_o = (level != '0);
    assign rd_data_o  = rd_valid_o ? mem[rd_ptr] : '0;
    assign level_o    = level;
    assign busy_o     = in_shift;
    assign err_len_o  = err_len;
    assign ovf_o      = ovf;
    assign irq_o      = irq;

endmodule

// File: tb/tb_rlbp_code_collector.sv
// Directed bench for rlbp_code_collector: queue-based frame/FIFO model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_rlbp_code_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, bit_in, bit_vld, done, rd_en, clr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  level;
    logic        busy, err_len, ovf, irq;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    rlbp_code_collector #(
        .CODE_BITS(12), .TAG_BITS(4), .DEPTH(8), .IRQ_THR(4)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .start_i    (start),
        .bit_i      (bit_in),
        .bit_vld_i  (bit_vld),
        .done_i     (done),
        .rd_en_i    (rd_en),
        .clr_flags_i(clr),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .level_o    (level),
        .busy_o     (busy),
        .err_len_o  (err_len),
        .ovf_o      (ovf),
        .irq_o      (irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] exp_q[$];
    bit          m_bits[$];
    bit          m_busy, m_err, m_ovf, m_irq;
    int          m_tag;
    int          m_pre;
    bit          m_pop, m_good, m_eset, m_oset, m_irq_next;
    logic [11:0] m_code;
    logic [15:0] m_ent;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_bits.delete();
            m_busy = 0; m_err = 0; m_ovf = 0; m_irq = 0; m_tag = 0;
        end else begin
            m_pre      = exp_q.size();
            m_pop      = rd_en && (m_pre > 0);
            m_irq_next = (m_pre >= 4) || m_err || m_ovf;
            m_eset = 0; m_oset = 0; m_good = 0; m_ent = '0;
            if (m_busy) begin
                if (bit_vld) m_bits.push_back(bit_in);
                if (done) begin
                    if (m_bits.size() == 12) begin
                        m_good = 1;
                        m_code = '0;
                        foreach (m_bits[k]) m_code[11-k] = m_bits[k];
                        m_ent = {4'(m_tag), m_code};
                    end else begin
                        m_eset = 1;
                    end
                    m_tag  = (m_tag + 1) % 16;
                    m_busy = start;
                    m_bits.delete();
                end else if (start) begin
                    m_eset = 1;
                    m_bits.delete();
                end
            end else if (start) begin
                m_busy = 1;
                m_bits.delete();
            end
            if (m_pop) void'(exp_q.pop_front());
            if (m_good) begin
                if (m_pre == 8 && !m_pop) m_oset = 1;
                else exp_q.push_back(m_ent);
            end
            m_err = m_eset || (m_err && !clr);
            m_ovf = m_oset || (m_ovf && !clr);
            m_irq = m_irq_next;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle after the first reset
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
            chk("rd_data",  32'(rd_data),  (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
            chk("level",    32'(level),    32'(exp_q.size()));
            chk("busy",     32'(busy),     32'(m_busy));
            chk("err_len",  32'(err_len),  32'(m_err));
            chk("ovf",      32'(ovf),      32'(m_ovf));
            chk("irq",      32'(irq),      32'(m_irq));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; bit_in = 0; bit_vld = 0; done = 0; rd_en = 0; clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        chk_en = 1;
    endtask

    task automatic send_bits(input logic [11:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            bit_vld = 1;
            bit_in  = code[11-i];
            tick();
        end
        bit_vld = 0;
        bit_in  = 0;
    endtask

    task automatic send_frame(input logic [11:0] code, input int n, input bit coinc, input bit rd);
        start = 1; tick(); start = 0;
        if (coinc) begin
            send_bits(code, n - 1);
            bit_vld = 1; bit_in = code[12-n]; done = 1; rd_en = rd;
            tick();
        end else begin
            send_bits(code, n);
            tick();
            done = 1; rd_en = rd;
            tick();
        end
        idle_inputs();
    endtask

    task automatic pop_one();
        rd_en = 1; tick(); rd_en = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        tick();
        do_reset();
        chk("reset_level", 32'(level), 32'h0);
        chk("reset_data",  32'(rd_data), 32'h0);

        // clean frame 1,0,1,1,0,0,1,0,1,0,0,1
        send_frame(12'hB29, 12, 0, 0);
        chk("clean_valid", 32'(rd_valid), 32'h1);
        chk("clean_data",  32'(rd_data), 32'h0B29);
        chk("clean_level", 32'(level), 32'h1);
        chk("clean_err",   32'(err_len), 32'h0);
        pop_one();
        chk("clean_empty", 32'(rd_valid), 32'h0);

        // last bit coincident with done; short frame; next tag is 2
        do_reset();
        send_frame(12'hA5C, 12, 1, 0);
        chk("coinc_data", 32'(rd_data), 32'h0A5C);
        send_frame(12'h123, 11, 0, 0);
        chk("short_err",   32'(err_len), 32'h1);
        chk("short_level", 32'(level), 32'h1);
        send_frame(12'h3F0, 12, 0, 0);
        pop_one();
        chk("tag2_data", 32'(rd_data), 32'h23F0);

        // overflow: 9 frames, no reads
        do_reset();
        for (int i = 0; i < 9; i++) send_frame(12'(i * 37 + 5), 12, 0, 0);
        chk("ovf_level", 32'(level), 32'h8);
        chk("ovf_flag",  32'(ovf), 32'h1);
        chk("ovf_irq",   32'(irq), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_tag", 32'(rd_data[15:12]), 32'(i));
            chk("drain_code", 32'(rd_data[11:0]), 32'(12'(i * 37 + 5)));
            pop_one();
        end
        chk("drain_empty", 32'(rd_valid), 32'h0);
        clr = 1; tick(); clr = 0;
        chk("clr_ovf", 32'(ovf), 32'h0);
        chk("clr_irq_lag", 32'(irq), 32'h1);
        tick();
        chk("clr_irq", 32'(irq), 32'h0);

        // full push + pop in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(12'(i + 16), 12, 0, 0);
        send_frame(12'h777, 12, 0, 1);
        chk("fpp_level", 32'(level), 32'h8);
        chk("fpp_head",  32'(rd_data[15:12]), 32'h1);
        chk("fpp_ovf",   32'(ovf), 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("fpp_tail", 32'(rd_data), 32'h8777);
            pop_one();
        end

        // abort after 5 bits, then a clean frame
        do_reset();
        start = 1; tick(); start = 0;
        send_bits(12'hFFF, 5);
        start = 1; tick(); start = 0;
        chk("abort_err",  32'(err_len), 32'h1);
        chk("abort_busy", 32'(busy), 32'h1);
        send_bits(12'h5A5, 12);
        tick();
        done = 1; tick(); done = 0;
        chk("abort_data", 32'(rd_data), 32'h05A5);

        // reset mid-frame with 3 entries buffered
        send_frame(12'h111, 12, 0, 0);
        send_frame(12'h222, 12, 0, 0);
        chk("pre_rst_level", 32'(level), 32'h3);
        start = 1; tick(); start = 0;
        send_bits(12'hABC, 4);
        rst_n = 0; tick();
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_valid", 32'(rd_valid), 32'h0);
        chk("rst_data",  32'(rd_data), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_flags", 32'({err_len, ovf, irq}), 32'h0);
        rst_n = 1; tick();
        send_frame(12'hC3C, 12, 0, 0);
        chk("post_rst_data", 32'(rd_data), 32'h0C3C);

        // tag wrap with continuous draining
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_frame(12'(i * 101), 12, 0, 0);
            chk("wrap_tag", 32'(rd_data[15:12]), 32'(i % 16));
            pop_one();
        end
        for (int i = 0; i < 4; i++) begin
            send_frame(12'(i + 3), 12, 0, 0);
            if (i == 2) chk("irq_lvl3", 32'(irq), 32'h0);
        end
        chk("irq_lvl4_level", 32'(level), 32'h4);
        chk("irq_lvl4_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_lvl4", 32'(irq), 32'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
